muxn_arb: RTL

- Parameterised N-channel arbitrated multiplexer with a valid/ready handshake on every input and on the output.
- Successor to the combinational 2:1 mux. It selects one of CH requesting channels, either round-robin or fixed-priority.
- Output is registered: one-entry pipeline stage, full throughput.
- Used where several producers share one datapath, e.g. writeback-source or memory-request merging.

---
 rtl/muxn_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 59 +++++
 rtl/muxn_arb.sv | 91 +++++++++
 3 files changed

// File: rtl/muxn_pkg.sv
// Shared types and helpers for the arbitrated N-channel multiplexer.
package muxn_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int MAX_CH = 16;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // OR-encode a one-hot vector; an all-zero input yields index 0.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter: round-robin from a rotating pointer, or fixed
// lowest-index priority. Owns the round-robin pointer.
module rr_arbiter
  import muxn_pkg::*;
#(
  parameter int CH  = 4,
  parameter int RR  = 1,
  parameter int CHW = clog2_min1(CH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CH-1:0]  req,
  input  logic           advance,
  output logic [CH-1:0]  grant,
  output logic [CHW-1:0] grant_idx,
  output logic           any
);

  localparam arb_mode_e MODE = (RR != 0) ? ARB_RR : ARB_FIXED;

  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] base;

  assign base = (MODE == ARB_RR) ? ptr_q : '0;

  // Scan from the base index upward, wrapping modulo CH; first requester wins.
  always_comb begin
    logic           found;
    int             slot;
    logic [CHW-1:0] idx;
    grant = '0;
    found = 1'b0;
    slot  = 0;
    idx   = '0;
    for (int k = 0; k < CH; k++) begin
      slot = int'(base) + k;
      if (slot >= CH) slot = slot - CH;
      idx = CHW'(slot);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign grant_idx = CHW'(onehot_to_idx(MAX_CH'(grant)));
  assign any       = |req;

  assign ptr_d = (grant_idx == CHW'(CH - 1)) ? '0 : grant_idx + CHW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && (MODE == ARB_RR) && (CH > 1)) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// N-channel arbitrated multiplexer with valid/ready on every input and a
// registered, full-throughput output stage.
module muxn_arb
  import muxn_pkg::*;
#(
  parameter int n   = 32,
  parameter int CH  = 4,
  parameter int RR  = 1,
  parameter int CHW = clog2_min1(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*n-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [n-1:0]    Y,
  output logic [CHW-1:0]  out_ch
);

  // Handshakes: a transfer happens on a port at a clk edge where its valid
  // and ready are both high. in_ready depends on out_ready only through load,
  // and the grant never looks at ready, so there is no combinational loop.

  logic [CH-1:0]  grant;
  logic [CHW-1:0] grant_idx;
  logic           any_req;
  logic           load;
  logic           xfer_in;
  logic [n-1:0]   sel_data;

  logic           out_valid_q, out_valid_d;
  logic [n-1:0]   y_q, y_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;

  rr_arbiter #(
    .CH  (CH),
    .RR  (RR),
    .CHW (CHW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (xfer_in),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  assign load     = !out_valid_q | out_ready;
  assign in_ready = grant & {CH{load & rst_n}};
  assign xfer_in  = any_req & load & rst_n;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CH; i++) begin
      sel_data = sel_data | (in_data[i*n +: n] & {n{grant[i]}});
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    out_ch_d    = out_ch_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      y_d         = sel_data;
      out_ch_d    = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign out_ch    = out_ch_q;

endmodule
